// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU constants for the fetch path: reset vector, instruction window size,
// word increment, plus the fetch FSM state and FIFO entry types.
package fetch_ctrl_pkg;

   localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;
   localparam int unsigned CPU_IM_WORDS = 1024;
   localparam logic [31:0] CPU_WORD_INC = 32'd4;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_q.sv
// Two-entry FIFO for fetched {pc, instr} pairs. Flush wins over push/pop in the same cycle.
module fetch_q (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  logic [63:0] din,
   output logic [63:0] dout,
   output logic        full,
   output logic        empty
);

   logic [63:0] mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;

   // A push into a full queue is only legal alongside a pop; the write then lands in
   // the slot being vacated, which becomes the new tail.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the fetch PC to a combinational instruction
// memory, buffers fetched words for decode and faults on out-of-window fetches.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = CPU_RESET_PC,
   parameter int unsigned IM_WORDS = CPU_IM_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] im_pc,
   input  logic [31:0] im_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        fault
);

   // 33-bit bounds so a window ending at 2^32 does not wrap.
   localparam logic [32:0] WIN_LO = {1'b0, RESET_PC};
   localparam logic [32:0] WIN_HI = WIN_LO + 33'(IM_WORDS) * {1'b0, CPU_WORD_INC};

   fetch_state_t state_q, state_d;
   logic [31:0]  fpc_q, fpc_d;
   logic         push, pop, flush, full, empty, in_window;
   fetch_entry_t entry_in, head;
   logic [63:0]  head_raw;

   assign im_pc     = fpc_q;
   assign in_window = ({1'b0, fpc_q} >= WIN_LO) && ({1'b0, fpc_q} < WIN_HI)
                      && (fpc_q[1:0] == 2'b00);
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign entry_in  = '{pc: fpc_q, instr: im_instr};
   assign head      = fetch_entry_t'(head_raw);
   assign out_pc    = head.pc;
   assign out_instr = head.instr;
   assign fault     = (state_q == FAULT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         fpc_q   <= RESET_PC;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
      end
   end

   // Redirect outranks the window check, so a bad target is only caught once it sits in fpc.
   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      push    = 1'b0;
      flush   = 1'b0;
      if (state_q == RUN) begin
         if (redirect_valid) begin
            flush = 1'b1;
            fpc_d = redirect_pc;
         end else if (!in_window) begin
            state_d = FAULT;
         end else if (!full || pop) begin
            push  = 1'b1;
            fpc_d = fpc_q + CPU_WORD_INC;
         end
      end
   end

   fetch_q u_fetch_q (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (entry_in),
      .dout  (head_raw),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a combinational instruction memory model.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] im_pc;
   logic [31:0] im_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        fault;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .im_pc          (im_pc),
      .im_instr       (im_instr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .fault          (fault)
   );

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   assign im_instr = memWord(im_pc);

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
      reset          = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkHead(input string tag, input logic [31:0] pc);
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_pc"}, out_pc, pc);
      checkOutput({tag, "_instr"}, out_instr, memWord(pc));
   endtask

   initial begin
      logic [31:0] exp_pc;
      logic [31:0] last_pc;

      // Reset state and streaming with decode always ready
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_impc", im_pc, 32'h3000);
      checkOutput("rst_fault", 32'(fault), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkHead("str0", 32'h3000);
      tick();
      checkHead("str1", 32'h3004);
      tick();
      checkHead("str2", 32'h3008);

      // Backpressure: fill both entries and hold
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bp_head", out_pc, 32'h3000);
      end
      checkOutput("bp_impc", im_pc, 32'h3008);
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkHead("bp1", 32'h3004);
      tick();
      checkHead("bp2", 32'h3008);

      // Redirect with both entries buffered and a same-cycle handshake
      applyStimulus(1'b0, 1'b1, 32'h3100, 1'b1);
      tick();
      checkOutput("rd_valid", 32'(out_valid), 32'd0);
      checkOutput("rd_impc", im_pc, 32'h3100);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkHead("rd0", 32'h3100);
      tick();
      checkHead("rd1", 32'h3104);

      // Misaligned redirect faults a cycle later; later redirects ignored
      applyStimulus(1'b0, 1'b1, 32'h3102, 1'b1);
      tick();
      checkOutput("mis_fault0", 32'(fault), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkOutput("mis_fault1", 32'(fault), 32'd1);
      checkOutput("mis_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b0, 1'b1, 32'h3000, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("flt_impc", im_pc, 32'h3102);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("flt_valid", 32'(out_valid), 32'd0);
         checkOutput("flt_sticky", 32'(fault), 32'd1);
      end

      // Reset clears the fault
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      checkOutput("clr_fault", 32'(fault), 32'd0);
      checkOutput("clr_impc", im_pc, 32'h3000);

      // Entries buffered before a window fault still drain
      applyStimulus(1'b0, 1'b1, 32'h3FFC, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      tick();
      checkOutput("drn_fault", 32'(fault), 32'd1);
      checkHead("drn", 32'h3FFC);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkOutput("drn_empty", 32'(out_valid), 32'd0);

      // Sequential fetch to the end of the window
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      exp_pc  = 32'h3000;
      last_pc = 32'h0;
      for (int i = 0; i < 1030; i++) begin
         tick();
         if (out_valid) begin
            checkOutput("seq_pc", out_pc, exp_pc);
            checkOutput("seq_instr", out_instr, memWord(exp_pc));
            last_pc = out_pc;
            exp_pc  = exp_pc + 32'd4;
         end
      end
      checkOutput("seq_last", last_pc, 32'h3FFC);
      checkOutput("seq_fault", 32'(fault), 32'd1);
      checkOutput("seq_valid", 32'(out_valid), 32'd0);

      // Reset with a full FIFO and a same-cycle redirect
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      tick();
      checkOutput("full_impc", im_pc, 32'h3008);
      applyStimulus(1'b1, 1'b1, 32'h3100, 1'b1);
      tick();
      checkOutput("rr_valid", 32'(out_valid), 32'd0);
      checkOutput("rr_impc", im_pc, 32'h3000);
      checkOutput("rr_fault", 32'(fault), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkHead("rr0", 32'h3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'h0000_3000, the first fetch address after reset.
REQ-002 The block SHALL expose parameter IM_WORDS, default 1024, the number of 32-bit words in the instruction memory window starting at RESET_PC.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port redirect_valid, input, 1: a branch/jump redirect request this cycle.
REQ-006 Port redirect_pc, input, 32: the redirect target address.
REQ-007 Port im_pc, output, 32: the address driven to the combinational instruction memory.
REQ-008 Port im_instr, input, 32: the memory word at im_pc, valid in the same cycle.
REQ-009 Port out_valid, output, 1: a fetched instruction is presented to decode.
REQ-010 Port out_ready, input, 1: decode accepts the presented instruction.
REQ-011 Port out_pc, output, 32: the address of the presented instruction.
REQ-012 Port out_instr, output, 32: the presented instruction word.
REQ-013 Port fault, output, 1: sticky fetch-fault flag.

Function
REQ-014 The block SHALL hold the fetch PC (fpc) in a register and SHALL drive im_pc = fpc combinationally.
REQ-015 The block SHALL buffer fetched {pc, instr} pairs in a 2-entry FIFO; out_valid = (count != 0); out_pc/out_instr = head entry.
REQ-016 A pop SHALL occur when out_valid && out_ready.
REQ-017 A push of {fpc, im_instr} SHALL occur, with fpc <= fpc + 4 (mod 2^32), when state = RUN, redirect_valid = 0, fpc is in-window, and (count < 2 or a pop occurs this cycle).
REQ-018 When full with no pop, fpc and the FIFO SHALL hold; out_pc/out_instr SHALL remain stable while out_valid && !out_ready.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-020 Throughput SHALL be one instruction per cycle with out_ready held high; latency from fpc update to out_valid SHALL be 1 cycle.
REQ-021 State machine: RUN and FAULT; reset SHALL enter RUN.
REQ-022 Window: fpc is in-window iff RESET_PC <= fpc < RESET_PC + 4*IM_WORDS and fpc[1:0] = 0.
REQ-023 In RUN, if fpc is out-of-window and redirect_valid = 0, the block SHALL set fault, enter FAULT and push nothing; already-buffered entries SHALL still drain.
REQ-024 In RUN, redirect_valid = 1 SHALL flush the FIFO (count <= 0, overriding any same-cycle pop or push) and load fpc <= redirect_pc; no push SHALL occur that cycle.
REQ-025 A handshake completing in the redirect cycle SHALL count as consumed by decode; the flushed entries SHALL never reappear.
REQ-026 A misaligned or out-of-window redirect_pc SHALL be accepted into fpc and SHALL fault on the next cycle per REQ-023.
REQ-027 In FAULT, redirect_valid SHALL be ignored, no push SHALL occur, and fault SHALL stay 1 until reset.

Reset
REQ-028 On reset, the block SHALL set fpc = RESET_PC, count = 0, out_valid = 0, fault = 0 and state = RUN, and SHALL clear the FIFO pointers.
REQ-029 Reset SHALL override a same-cycle redirect, push or pop.
REQ-030 Reset mid-stream SHALL discard all buffered entries.
REQ-031 The first cycle after reset SHALL push RESET_PC; out_valid SHALL be 1 in the second cycle after reset.

Structure
REQ-032 RESET_PC, IM_WORDS and the word-increment constant (4) SHALL live in the shared CPU constants header used by the instruction-memory and datapath blocks.
REQ-033 The 2-entry FIFO SHALL be a sub-module fetch_q, with push/pop/flush/full/empty ports and a 64-bit data width.
REQ-034 fpc control and the RUN/FAULT FSM SHALL be in fetch_ctrl itself.

Verification
REQ-035 Reset, then out_ready = 1 for 4 cycles -> out_pc = 0x3000, 0x3004, 0x3008 on consecutive cycles, with out_instr matching memory.
REQ-036 Hold out_ready = 0 for 5 cycles after reset -> count reaches 2, im_pc = 0x3008 and held, head remains 0x3000; then out_ready = 1 -> 0x3000, 0x3004, 0x3008 with no gap or duplicate.
REQ-037 Redirect to 0x3100 while 2 entries are buffered and out_ready = 1 -> the head is consumed that cycle, out_valid = 0 next cycle, then out_pc = 0x3100.
REQ-038 Redirect to 0x3102 -> fault = 1 one cycle later; a later redirect to 0x3000 is ignored; out_valid stays 0 once drained.
REQ-039 Sequential fetch reaching 0x3000 + 4*1024 = 0x4000 -> last delivered pc = 0x3FFC, fault = 1.
REQ-040 Assert reset with a full FIFO and a same-cycle redirect -> next cycle count = 0, fpc = 0x3000, fault = 0.
